line_clock: RTL
===============

LINE_CLOCK -- requirements
Module: line_clock

Interface
REQ-001 Parameter CLK_HZ, default 100000000: clk_p frequency in Hz.
REQ-002 Parameter TICK_HZ, default 50: line-clock tick rate in Hz (50 or 60 typical).
REQ-003 Parameter DEB_DEPTH, default 2: number of consecutive tick-rate button samples needed for a stable level (range 2..8).
REQ-004 Parameter MODE, default 1: 0 = EVNT pulse mode (M2 style), 1 = KW11-L vectored mode with CSR.
REQ-005 Parameter VECTOR, default 16'o000100: interrupt vector returned in MODE 1.
REQ-006 clk_p  in  1  sole clock; every register updates on its rising edge.
REQ-007 dclo  in  1  reset; synchronous, active-high.
REQ-008 wb_stb_i  in  1  CSR access strobe, already address-decoded for 177546.
REQ-009 wb_we_i  in  1  write enable.
REQ-010 wb_sel_i  in  2  byte lanes.
REQ-011 wb_dat_i  in  16  write data.
REQ-012 wb_dat_o  out  16  read data.
REQ-013 wb_ack_o  out  1  access acknowledge.
REQ-014 virq  out  1  vectored interrupt request.
REQ-015 istb  in  1  vector read strobe from the CPU.
REQ-016 iack  out  1  vector acknowledge.
REQ-017 ivec  out  16  vector bus.
REQ-018 evnt  out  1  one-cycle event pulse to the CPU EVNT input.
REQ-019 timer_button  in  1  raw enable/disable button.
REQ-020 timer_status  out  1  timer-enabled indicator.

Function
REQ-021 Prescaler counts 0..CLK_HZ/TICK_HZ-1 and wraps; tick is a one-cycle internal pulse on the wrap cycle; width is $clog2(CLK_HZ/TICK_HZ).
REQ-022 Button is sampled only on tick cycles into a DEB_DEPTH shift register; all-ones with latch clear toggles timer_status and sets the latch; all-zeros clears the latch; mixed values hold.
REQ-023 evnt equals tick AND timer_status when MODE=0; it is held 0 when MODE=1.
REQ-024 CSR bit 7 (MON) is set on every tick regardless of timer_status; a write with sel[0]=1 loads bit 7 from wb_dat_i[7].
REQ-025 CSR bit 6 (IE) is read/write via sel[0]; all other CSR bits read 0 and ignore writes.
REQ-026 Tick in the same cycle as a write clearing MON leaves MON=1 (tick wins).
REQ-027 wb_ack_o asserts the cycle after wb_stb_i rises and is a single-cycle pulse per access; wb_dat_o is valid while wb_ack_o=1 and 0 otherwise.
REQ-028 In MODE 0 the CSR still responds, but IE has no interrupt effect.
REQ-029 In MODE 1, a tick with IE=1 and timer_status=1 sets pending; virq mirrors pending.
REQ-030 A tick while pending is already set is lost; there is no queueing.
REQ-031 Interrupt FSM states are IDLE, PEND and ACK: IDLE->PEND on a qualifying tick; PEND->ACK when istb=1; PEND->IDLE when IE is cleared; ACK->IDLE when istb=0.
REQ-032 In ACK, iack=1, ivec=VECTOR and pending clears; otherwise iack=0 and ivec=0.
REQ-033 Clearing IE or timer_status during ACK does not abort the handshake.

Reset
REQ-034 dclo=1 clears prescaler, debounce register, latch, timer_status, MON, IE and the FSM (IDLE) in the same edge; all outputs are 0 on the following cycle.
REQ-035 dclo asserted mid-handshake drops iack immediately without waiting for istb.

Structure
REQ-036 The CSR address 177546, bit positions MON=7 and IE=6, and the default vector live in a shared package.
REQ-037 The debouncer and toggle logic form one sub-module, btn_debounce, parametrised by DEB_DEPTH with a sample-enable input.

Verification (CLK_HZ=1000, TICK_HZ=100, i.e. tick every 10 cycles)
REQ-038 Reset released, no access -> tick at cycles 9, 19, 29; MON reads 1 after the first tick; virq stays 0.
REQ-039 MODE=0, button held 1 for 3 ticks -> timer_status toggles to 1 exactly once; evnt pulses one cycle per tick thereafter; releasing for 2 ticks, then pressing, toggles it to 0.
REQ-040 MODE=1, timer_status=1, write 0o100 -> virq=1 at the next tick; istb=1 -> next cycle iack=1, ivec=0o100, virq=0; istb=0 -> iack=0.
REQ-041 Write 0o000 (clear MON) on the tick cycle -> MON reads 1.
REQ-042 Pending, then write 0 to IE -> virq=0 next cycle; a later istb gets no iack.
REQ-043 dclo pulsed while iack=1 -> iack, virq, timer_status and CSR read 0; the prescaler restarts at 0.

Source files
------------

// File: rtl/line_clock_pkg.sv
// line_clock_pkg -- shared constants and types for the line-clock block.
//   CSR_ADDR       : bus address of the line-clock CSR (decoded outside this block)
//   MON_BIT/IE_BIT : CSR bit positions for the monitor and interrupt-enable bits
//   DEFAULT_VECTOR : interrupt vector returned during the vector handshake
//   irq_state_t    : interrupt handshake FSM states
//   csr_word()     : assembles the CSR read value from its two live bits
package line_clock_pkg;

   localparam logic [15:0] CSR_ADDR       = 16'o177546;
   localparam int          MON_BIT        = 7;
   localparam int          IE_BIT         = 6;
   localparam logic [15:0] DEFAULT_VECTOR = 16'o000100;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_PEND = 2'd1,
      IRQ_ACK  = 2'd2
   } irq_state_t;

   function automatic logic [15:0] csr_word(input logic mon, input logic ie);
      logic [15:0] w;
      w          = '0;
      w[MON_BIT] = mon;
      w[IE_BIT]  = ie;
      return w;
   endfunction

endpackage

// File: rtl/line_clock_btn_debounce.sv
// btn_debounce -- tick-rate debouncer and toggle for the timer enable button.
//   clk_p     in  : clock
//   dclo      in  : synchronous active-high reset
//   sample_en in  : one-cycle strobe; the button is shifted in only on this strobe
//   button    in  : raw, asynchronous push button
//   status    out : toggled state (one toggle per stable press)
module btn_debounce
   import line_clock_pkg::*;
#(
   parameter int DEB_DEPTH = 2
) (
   input  logic clk_p,
   input  logic dclo,
   input  logic sample_en,
   input  logic button,
   output logic status
);

   // Two-flop synchroniser: the raw button has no relation to clk_p.
   logic [1:0]           sync;
   logic [DEB_DEPTH-1:0] sr;
   // Latch remembers that the current press has already been acted on,
   // so a held button toggles only once until it is seen fully released.
   logic                 latch;

   always_ff @(posedge clk_p) begin
      if (dclo) begin
         sync   <= '0;
         sr     <= '0;
         latch  <= 1'b0;
         status <= 1'b0;
      end else begin
         sync <= {sync[0], button};
         if (sample_en) begin
            sr <= {sr[DEB_DEPTH-2:0], sync[1]};
         end
         if ((&sr) && !latch) begin
            status <= ~status;
            latch  <= 1'b1;
         end else if (sr == '0) begin
            latch <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/line_clock.sv
// line_clock -- line-frequency clock with KW11-L style CSR and vectored interrupt.
//   clk_p, dclo             : clock, synchronous active-high reset
//   wb_stb_i/we_i/sel_i/dat_i: CSR access (strobe already address-decoded)
//   wb_dat_o, wb_ack_o      : CSR read data (valid only with ack), one-cycle ack
//   virq                    : interrupt request (pending)
//   istb, iack, ivec        : vector read handshake
//   evnt                    : one-cycle event pulse (MODE 0 only)
//   timer_button            : raw enable/disable button
//   timer_status            : timer-enabled indicator
//   dbg_state               : interrupt FSM state for observation
// Handshake: an access is accepted on the first cycle wb_stb_i is high after
// being low; wb_ack_o follows one cycle later for exactly one cycle, and the
// master must drop wb_stb_i for at least one cycle before the next access.
// The vector handshake holds iack while istb stays high.
module line_clock
   import line_clock_pkg::*;
#(
   parameter int          CLK_HZ    = 100000000,
   parameter int          TICK_HZ   = 50,
   parameter int          DEB_DEPTH = 2,
   parameter int          MODE      = 1,
   parameter logic [15:0] VECTOR    = DEFAULT_VECTOR
) (
   input  logic        clk_p,
   input  logic        dclo,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [1:0]  wb_sel_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        virq,
   input  logic        istb,
   output logic        iack,
   output logic [15:0] ivec,
   output logic        evnt,
   input  logic        timer_button,
   output logic        timer_status,
   output irq_state_t  dbg_state
);

   localparam int            DIV  = CLK_HZ / TICK_HZ;
   localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   logic [PW-1:0] presc;
   logic          tick;
   logic          stb_q;
   logic          access;
   logic          wr_lo;
   logic          mon;
   logic          ie;
   irq_state_t    state;
   irq_state_t    state_nxt;
   logic          unused_bits;

   // Only the low byte lane and bits 7/6 carry state.
   assign unused_bits = ^{wb_dat_i[15:8], wb_dat_i[5:0], wb_sel_i[1]};

   // Prescaler: tick is the wrap cycle.
   always_ff @(posedge clk_p) begin
      if (dclo || presc == PMAX) presc <= '0;
      else                       presc <= presc + 1'b1;
   end
   assign tick = (presc == PMAX);

   btn_debounce #(.DEB_DEPTH(DEB_DEPTH)) u_btn (
      .clk_p    (clk_p),
      .dclo     (dclo),
      .sample_en(tick),
      .button   (timer_button),
      .status   (timer_status)
   );

   assign access = wb_stb_i & ~stb_q;
   assign wr_lo  = access & wb_we_i & wb_sel_i[0];

   // CSR. The tick assignment comes last so a same-cycle write clearing
   // MON loses to the tick.
   always_ff @(posedge clk_p) begin
      if (dclo) begin
         stb_q    <= 1'b0;
         wb_ack_o <= 1'b0;
         mon      <= 1'b0;
         ie       <= 1'b0;
      end else begin
         stb_q    <= wb_stb_i;
         wb_ack_o <= access;
         if (wr_lo) begin
            mon <= wb_dat_i[MON_BIT];
            ie  <= wb_dat_i[IE_BIT];
         end
         if (tick) mon <= 1'b1;
      end
   end

   assign wb_dat_o = wb_ack_o ? csr_word(mon, ie) : 16'h0000;

   // Interrupt FSM. Ticks arriving outside IDLE are dropped; ACK ignores IE
   // and timer_status so a started handshake always completes.
   always_ff @(posedge clk_p) begin
      if (dclo) state <= IRQ_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IRQ_IDLE: if (MODE == 1 && tick && ie && timer_status) state_nxt = IRQ_PEND;
         IRQ_PEND: begin
            if (istb)     state_nxt = IRQ_ACK;
            else if (!ie) state_nxt = IRQ_IDLE;
         end
         IRQ_ACK:  if (!istb) state_nxt = IRQ_IDLE;
         default:  state_nxt = IRQ_IDLE;
      endcase
   end

   assign virq      = (state == IRQ_PEND);
   assign iack      = (state == IRQ_ACK);
   assign ivec      = iack ? VECTOR : 16'h0000;
   assign evnt      = (MODE == 0) ? (tick & timer_status) : 1'b0;
   assign dbg_state = state;

endmodule
